// File: rtl/fsm_pkg.sv
// Shared state encoding and default sizing for the serial pattern transmitter
// and the sequence detector that consumes its stream.
`timescale 1ns/1ps
package fsm_pkg;
  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_SHIFT = 2'd1;
  localparam state_t ST_GAP   = 2'd2;
  localparam state_t ST_DONE  = 2'd3;

  localparam int DEF_MAX_LEN = 8;
  localparam int DEF_GAP     = 1;
endpackage

// File: rtl/piso_shift.sv
// Parallel-load, MSB-first shift register; dout is always the current MSB.
`timescale 1ns/1ps
module piso_shift #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         load,
  input  logic         shift,
  input  logic [W-1:0] din,
  output logic         dout
);
  logic [W-1:0] sr;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)      sr <= '0;
    else if (load)  sr <= din;
    else if (shift) sr <= {sr[W-2:0], 1'b0};
  end

  assign dout = sr[W-1];
endmodule

// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: latches a pattern on start and shifts it out
// MSB-first, optionally repeating with an idle gap, then pulses done.
`timescale 1ns/1ps
module seq_pattern_tx
  import fsm_pkg::*;
#(
  parameter int MAX_LEN = DEF_MAX_LEN,
  parameter int LEN_W   = 4,
  parameter int REP_W   = 3,
  parameter int GAP     = DEF_GAP
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               start,
  input  logic [MAX_LEN-1:0] pattern,
  input  logic [LEN_W-1:0]   len,
  input  logic [REP_W-1:0]   reps,
  output logic               out,
  output logic               valid,
  output logic               busy,
  output logic               done,
  output logic               err
);
  localparam int GAP_W  = (GAP > 1) ? $clog2(GAP) : 1;
  localparam int GAP_M1 = (GAP > 0) ? GAP - 1 : 0;

  state_t             state, nxt;
  logic [MAX_LEN-1:0] pat_q;
  logic [LEN_W-1:0]   len_q, bcnt;
  logic [REP_W-1:0]   rep_cnt;
  logic [GAP_W-1:0]   gcnt;
  logic               err_q;

  logic               can_start, len_ok, load_new, reload, shift_en, last_bit, sdo;
  logic [LEN_W-1:0]   sh;
  logic [MAX_LEN-1:0] aligned;

  // Left-align the pattern so bit len-1 sits at the shifter MSB.
  assign sh        = LEN_W'(MAX_LEN) - len;
  assign aligned   = pattern << sh;
  assign can_start = start && (state == ST_IDLE || state == ST_DONE);
  assign len_ok    = (len != '0) && (len <= LEN_W'(MAX_LEN));
  assign load_new  = can_start && len_ok;
  assign last_bit  = (state == ST_SHIFT) && (bcnt == '0);
  assign shift_en  = (state == ST_SHIFT) && (bcnt != '0);
  assign reload    = (last_bit && rep_cnt != '0 && GAP == 0) ||
                     (state == ST_GAP && gcnt == '0);

  piso_shift #(.W(MAX_LEN)) u_piso (
    .clk   (clk),
    .rstn  (rstn),
    .load  (load_new || reload),
    .shift (shift_en),
    .din   (load_new ? aligned : pat_q),
    .dout  (sdo)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= ST_IDLE;
    else       state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      ST_IDLE:  if (start) nxt = len_ok ? ST_SHIFT : ST_DONE;
      ST_SHIFT: if (bcnt == '0) begin
                  if (rep_cnt != '0) nxt = (GAP > 0) ? ST_GAP : ST_SHIFT;
                  else               nxt = ST_DONE;
                end
      ST_GAP:   if (gcnt == '0) nxt = ST_SHIFT;
      ST_DONE:  if (start) nxt = len_ok ? ST_SHIFT : ST_DONE;
                else       nxt = ST_IDLE;
      default:  nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    out   = 1'b0;
    valid = 1'b0;
    busy  = 1'b0;
    done  = 1'b0;
    err   = 1'b0;
    case (state)
      ST_SHIFT: begin out = sdo; valid = 1'b1; busy = 1'b1; end
      ST_GAP:   busy = 1'b1;
      ST_DONE:  begin done = 1'b1; err = err_q; end
      default:  ;
    endcase
  end

  // Latched command plus the bit, repetition and gap counters.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pat_q   <= '0;
      len_q   <= '0;
      bcnt    <= '0;
      rep_cnt <= '0;
      gcnt    <= '0;
      err_q   <= 1'b0;
    end else begin
      err_q <= can_start && !len_ok;
      if (load_new) begin
        pat_q   <= aligned;
        len_q   <= len;
        rep_cnt <= reps;
        bcnt    <= len - LEN_W'(1);
      end else begin
        if (shift_en)    bcnt <= bcnt - LEN_W'(1);
        else if (reload) bcnt <= len_q - LEN_W'(1);
        if (last_bit && rep_cnt != '0) rep_cnt <= rep_cnt - REP_W'(1);
      end
      if (last_bit && rep_cnt != '0) gcnt <= GAP_W'(GAP_M1);
      else if (state == ST_GAP)      gcnt <= gcnt - GAP_W'(1);
    end
  end
endmodule

// File: tb/tb_seq_pattern_tx.sv
// Scoreboard bench for seq_pattern_tx: expected bits and done records are
// queued when a command is issued and consumed as the stream comes out.
`timescale 1ns/100ps
module tb_seq_pattern_tx;
  localparam int MAX_LEN = 8;
  localparam int LEN_W   = 4;
  localparam int REP_W   = 3;
  localparam int GAP     = 1;

  logic               clk = 1'b0;
  logic               rstn = 1'b1;
  logic               start = 1'b0;
  logic [MAX_LEN-1:0] pattern = '0;
  logic [LEN_W-1:0]   len = '0;
  logic [REP_W-1:0]   reps = '0;
  logic               out, valid, busy, done, err;

  typedef struct {
    logic err;
    int   busy;
  } done_t;

  logic  exp_bits[$];
  done_t exp_done[$];
  int    checks = 0;
  int    errors = 0;
  int    busy_cnt = 0;

  always #5 clk = ~clk;

  seq_pattern_tx #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .REP_W(REP_W), .GAP(GAP)) dut (
    .clk     (clk),
    .rstn    (rstn),
    .start   (start),
    .pattern (pattern),
    .len     (len),
    .reps    (reps),
    .out     (out),
    .valid   (valid),
    .busy    (busy),
    .done    (done),
    .err     (err)
  );

  task automatic chk(input string tag, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0d want=%0d at %0t", tag, act, exp, $time);
    end
  endtask

  // Monitor: pops the scoreboard as bits and done pulses appear.
  always @(negedge clk) begin
    done_t d;
    if (rstn) begin
      if (busy) busy_cnt++;
      if (valid) begin
        if (exp_bits.size() == 0) chk("extra_bit", 1, 0);
        else                      chk("bit", int'(out), int'(exp_bits.pop_front()));
      end else begin
        chk("out_idle", int'(out), 0);
      end
      if (done) begin
        chk("done_busy", int'(busy), 0);
        if (exp_done.size() == 0) chk("extra_done", 1, 0);
        else begin
          d = exp_done.pop_front();
          chk("err", int'(err), int'(d.err));
          chk("busy_cycles", busy_cnt, d.busy);
        end
        busy_cnt = 0;
      end else begin
        chk("err_nodone", int'(err), 0);
      end
    end else begin
      busy_cnt = 0;
    end
  end

  task automatic expect_cmd(input logic [7:0] p, input int l, input int r);
    done_t d;
    if (l < 1 || l > MAX_LEN) begin
      d.err = 1'b1; d.busy = 0;
    end else begin
      for (int k = 0; k <= r; k++)
        for (int i = l - 1; i >= 0; i--) exp_bits.push_back(p[i]);
      d.err = 1'b0; d.busy = (r + 1) * l + r * GAP;
    end
    exp_done.push_back(d);
  endtask

  task automatic issue(input logic [7:0] p, input int l, input int r);
    pattern = p;
    len     = LEN_W'(l);
    reps    = REP_W'(r);
    start   = 1'b1;
    expect_cmd(p, l, r);
  endtask

  // Drive start for one edge, then check the first response cycle.
  task automatic send(input logic [7:0] p, input int l, input int r);
    @(negedge clk);
    issue(p, l, r);
    @(negedge clk);
    start = 1'b0;
    if (l >= 1 && l <= MAX_LEN) chk("first_bit_valid", int'(valid), 1);
    else                        chk("illegal_done", int'(done), 1);
  endtask

  task automatic wait_done();
    int n = 0;
    while (exp_done.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (exp_done.size() != 0) begin
      chk("timeout", 0, 1);
      exp_done.delete();
      exp_bits.delete();
    end
  endtask

  initial begin
    #0.1 rstn = 1'b0;
    start = 1'b1;
    #0.4 chk("rst_outs", int'({out, valid, busy, done, err}), 0);
    #0.5 start = 1'b0;
    #0.2 rstn = 1'b1;
    @(negedge clk);
    chk("post_rst_outs", int'({out, valid, busy, done, err}), 0);

    send(8'b0000_1101, 4, 0);
    wait_done();
    send(8'b0000_0101, 3, 2);
    wait_done();
    send(8'h5A, 0, 0);
    wait_done();
    send(8'h5A, 9, 0);
    wait_done();
    send(8'h81, 1, 3);
    wait_done();

    // start while busy is ignored; the original bits must still come out
    send(8'hB4, 8, 0);
    repeat (2) @(negedge clk);
    pattern = 8'hFF; len = 4'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done();

    // start sampled in the DONE cycle begins a new transfer on the next cycle
    send(8'h96, 5, 0);
    begin
      int n = 0;
      do begin @(negedge clk); n++; end while (!done && n < 100);
      chk("saw_done", int'(done), 1);
    end
    issue(8'h0E, 4, 1);
    @(negedge clk);
    start = 1'b0;
    chk("b2b_first_valid", int'(valid), 1);
    wait_done();

    // async reset on the third bit aborts with no done pulse
    send(8'hA5, 8, 0);
    repeat (2) @(negedge clk);
    #2 rstn = 1'b0;
    #1 chk("midrst_outs", int'({out, valid, busy, done, err}), 0);
    exp_bits.delete();
    exp_done.delete();
    repeat (2) @(negedge clk);
    #2 rstn = 1'b1;
    @(negedge clk);
    chk("midrst_no_done", int'(done), 0);
    chk("midrst_idle", int'(busy), 0);
    send(8'h3C, 8, 1);
    wait_done();

    repeat (3) @(negedge clk);
    chk("left_bits", exp_bits.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
